i2s_receiver: RTL

Captures a stereo 16-bit I2S stream from an external ADC/codec: the codec's serial data, bit clock and word clock are the receive-side counterpart of the audio_dout/audio_bclk/audio_lrclk lines the Audiosystem drives. Incoming signals are resynchronised into clk, each left/right word pair is deserialised, and complete stereo frames are buffered in a FIFO. The CPU drains the FIFO through an AXI-Lite read-only slave. The block sits next to the Audiosystem on the same CPU bus.

---
 rtl/i2s_receiver_if.sv | 18 +
 rtl/i2s_receiver.sv | 134 +++++++++++++
 2 files changed

// File: rtl/i2s_receiver_if.sv
// i2s_receiver_if: AXI-Lite read-only channel between the CPU (master) and the I2S receiver (slave)
interface i2s_receiver_if;
  logic [31:0] s_axil_araddr;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;
  modport master (
    output s_axil_araddr, s_axil_arvalid, s_axil_rready,
    input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );
  modport slave (
    input  s_axil_araddr, s_axil_arvalid, s_axil_rready,
    output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );
endinterface

// File: rtl/i2s_receiver.sv
// i2s_receiver: stereo I2S capture into a frame FIFO drained over AXI-Lite; I2S_RX_MONO_MIX_EN makes DATA reads return the mono mix
module i2s_receiver #(
  parameter int SAMPLE_BITS = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i2s_bclk,
  input  logic           i2s_lrclk,
  input  logic           i2s_din,
  i2s_receiver_if.slave  axil,
  output logic           irq_not_empty
);
  localparam int W  = SAMPLE_BITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(W + 1);
  typedef enum logic [1:0] {WAIT_SYNC, SHIFT, HOLD} state_t;
  logic [SYNC_STAGES-1:0] bclk_s, lr_s, din_s;
  logic bclk_q, lr_prev, lr_seen;
  logic bclk, lr, din, tick, boundary;
  assign bclk = bclk_s[SYNC_STAGES-1];
  assign lr   = lr_s[SYNC_STAGES-1];
  assign din  = din_s[SYNC_STAGES-1];
  assign tick = bclk & ~bclk_q;
  // the first tick after reset only records lrclk, so no boundary can be invented mid-word
  assign boundary = tick & lr_seen & (lr != lr_prev);
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_s  <= '0;
      lr_s    <= '0;
      din_s   <= '0;
      bclk_q  <= 1'b0;
      lr_prev <= 1'b0;
      lr_seen <= 1'b0;
    end else begin
      bclk_s <= SYNC_STAGES'({bclk_s, i2s_bclk});
      lr_s   <= SYNC_STAGES'({lr_s, i2s_lrclk});
      din_s  <= SYNC_STAGES'({din_s, i2s_din});
      bclk_q <= bclk;
      if (tick) begin
        lr_prev <= lr;
        lr_seen <= 1'b1;
      end
    end
  end
  state_t state;
  logic [BW-1:0] bit_cnt;
  logic ch, left_valid;
  logic [W-1:0] shreg, left_reg, word_nx;
  logic last, push;
  logic [2*W-1:0] push_data;
  assign word_nx   = {shreg[W-2:0], din};
  assign last      = bit_cnt == BW'(W - 1);
  assign push      = tick & ~boundary & (state == SHIFT) & last & ch & left_valid;
  assign push_data = {left_reg, word_nx};
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_SYNC;
      bit_cnt    <= '0;
      ch         <= 1'b0;
      left_valid <= 1'b0;
      shreg      <= '0;
      left_reg   <= '0;
    end else if (boundary) begin
      state   <= SHIFT;
      bit_cnt <= '0;
      ch      <= lr;
      if (state == SHIFT) left_valid <= 1'b0;
    end else if (tick && state == SHIFT) begin
      shreg   <= word_nx;
      bit_cnt <= bit_cnt + 1'b1;
      if (last) begin
        state <= HOLD;
        if (!ch) begin
          left_reg   <= word_nx;
          left_valid <= 1'b1;
        end else left_valid <= 1'b0;
      end
    end
  end
  logic [2*W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic overflow, empty, full, ar_hs, pop, st_rd, push_ok;
  logic [2*W-1:0] head;
  logic [31:0] data_word, status;
  assign empty   = count == '0;
  assign full    = count == CW'(FIFO_DEPTH);
  assign ar_hs   = axil.s_axil_arvalid & axil.s_axil_arready;
  assign pop     = ar_hs & ~axil.s_axil_araddr[2] & ~empty;
  assign st_rd   = ar_hs & axil.s_axil_araddr[2];
  assign push_ok = push & (~full | pop);
  assign head    = mem[rd_ptr];
  assign status  = {15'b0, overflow, 6'b0, full, empty, 8'(count)};
  always_ff @(posedge clk) if (push_ok) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CW'(push_ok) - CW'(pop);
      overflow <= (push & ~push_ok) | (overflow & ~st_rd);
    end
  end
  logic unused_bits;
`ifdef I2S_RX_MONO_MIX_EN
  logic signed [W:0] sum;
  // floor(average) of the two signed channels
  assign sum         = $signed({head[2*W-1], head[2*W-1:W]}) + $signed({head[W-1], head[W-1:0]});
  assign data_word   = 32'({sum[W:1], sum[W:1]});
  assign unused_bits = ^{axil.s_axil_araddr[31:3], axil.s_axil_araddr[1:0], sum[0]};
`else
  assign data_word   = 32'(head);
  assign unused_bits = ^{axil.s_axil_araddr[31:3], axil.s_axil_araddr[1:0]};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      axil.s_axil_rvalid <= 1'b0;
      axil.s_axil_rdata  <= '0;
    end else if (ar_hs) begin
      axil.s_axil_rvalid <= 1'b1;
      axil.s_axil_rdata  <= axil.s_axil_araddr[2] ? status : (empty ? 32'd0 : data_word);
    end else if (axil.s_axil_rready) axil.s_axil_rvalid <= 1'b0;
  end
  assign axil.s_axil_arready = ~axil.s_axil_rvalid;
  assign axil.s_axil_rresp   = 2'b00;
  assign irq_not_empty       = ~empty;
endmodule
